// File: rtl/usb_tx_sched_pkg.sv
// usb_tx_sched_pkg: shared constants and types for the USB transmit path.
// Holds SYNC/PID bytes, CRC16 parameters and the scheduler state encoding.
package usb_tx_sched_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  // 0x8005 bit-reversed, for the LSB-first shift register.
  localparam logic [15:0] CRC_POLY_REFL = 16'hA001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_DRAIN,
    S_GAP
  } state_e;

  // The reserved select value falls back to NAK.
  function automatic logic [7:0] hs_pid_byte(
    input logic [1:0] sel
  );
    case (sel)
      2'd0:    return PID_ACK;
      2'd2:    return PID_STALL;
      default: return PID_NAK;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: byte-wide update of the reflected USB CRC16.
// Pure combinational; shared by the transmit and receive paths.
module usb_crc16
  import usb_tx_sched_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Fold eight data bits, LSB first, into the running CRC.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i])
        crc_out = (crc_out >> 1) ^ CRC_POLY_REFL;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: packet sequencer and arbiter in front of usb_tx.
// Grants one request, streams SYNC/PID/payload/CRC, then holds a gap.
module usb_tx_sched
  import usb_tx_sched_pkg::*;
#(
  parameter int GAP_CYCLES = 16,
  parameter int MAX_LEN    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hs_req,
  input  logic [1:0]                   hs_pid,
  output logic                         hs_ack,
  input  logic                         dat_req,
  input  logic                         dat_pid,
  input  logic [$clog2(MAX_LEN+1)-1:0] dat_len,
  output logic                         dat_ack,
  input  logic [7:0]                   pl_data,
  input  logic                         pl_valid,
  output logic                         pl_rd,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  input  logic                         tx_rd,
  input  logic                         tx_en,
  output logic                         busy,
  output logic                         underrun
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  state_e        state, state_d;
  logic          vld, vld_d;
  logic [7:0]    data, data_d;
  logic [7:0]    pid, pid_d;
  logic          is_dat, is_dat_d;
  logic [LW-1:0] cnt, cnt_d;
  logic [15:0]   crc, crc_d, crc_nxt;
  logic [GW-1:0] gap, gap_d;

  // Fixed-content byte states share one handshake path.
  logic          fix;
  logic [7:0]    fix_byte;
  state_e        fix_next;

  usb_crc16 u_crc (
    .crc_in  (crc),
    .data    (pl_data),
    .crc_out (crc_nxt)
  );

  assign tx_valid = vld;
  assign tx_data  = data;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      vld    <= 1'b0;
      data   <= '0;
      pid    <= '0;
      is_dat <= 1'b0;
      cnt    <= '0;
      crc    <= CRC_INIT;
      gap    <= '0;
    end else begin
      state  <= state_d;
      vld    <= vld_d;
      data   <= data_d;
      pid    <= pid_d;
      is_dat <= is_dat_d;
      cnt    <= cnt_d;
      crc    <= crc_d;
      gap    <= gap_d;
    end
  end

  // Next-state, byte handshake and grant/pulse outputs.
  always_comb begin
    state_d  = state;
    vld_d    = vld;
    data_d   = data;
    pid_d    = pid;
    is_dat_d = is_dat;
    cnt_d    = cnt;
    crc_d    = crc;
    gap_d    = gap;
    hs_ack   = 1'b0;
    dat_ack  = 1'b0;
    pl_rd    = 1'b0;
    underrun = 1'b0;
    busy     = (state != S_IDLE);
    fix      = 1'b0;
    fix_byte = 8'h00;
    fix_next = state;

    unique case (state)
      S_IDLE: begin
        busy = hs_req | dat_req;
        if (hs_req) begin
          hs_ack   = 1'b1;
          pid_d    = hs_pid_byte(hs_pid);
          is_dat_d = 1'b0;
          state_d  = S_SYNC;
        end else if (dat_req) begin
          dat_ack  = 1'b1;
          pid_d    = dat_pid ? PID_DATA1
                             : PID_DATA0;
          is_dat_d = 1'b1;
          cnt_d    = (dat_len > LEN_MAX)
                     ? LEN_MAX : dat_len;
          crc_d    = CRC_INIT;
          state_d  = S_SYNC;
        end
      end
      S_SYNC: begin
        fix      = 1'b1;
        fix_byte = SYNC_BYTE;
        fix_next = S_PID;
      end
      S_PID: begin
        fix      = 1'b1;
        fix_byte = pid;
        if (!is_dat)
          fix_next = S_DRAIN;
        else if (cnt != '0)
          fix_next = S_DATA;
        else
          fix_next = S_CRC_LO;
      end
      S_DATA: begin
        if (!vld) begin
          if (pl_valid) begin
            pl_rd  = 1'b1;
            data_d = pl_data;
            vld_d  = 1'b1;
            crc_d  = crc_nxt;
            cnt_d  = cnt - LW'(1);
          end else begin
            underrun = 1'b1;
            state_d  = S_DRAIN;
          end
        end else if (tx_rd) begin
          vld_d   = 1'b0;
          state_d = (cnt == '0) ? S_CRC_LO
                                : S_DATA;
        end
      end
      S_CRC_LO: begin
        fix      = 1'b1;
        fix_byte = ~crc[7:0];
        fix_next = S_CRC_HI;
      end
      S_CRC_HI: begin
        fix      = 1'b1;
        fix_byte = ~crc[15:8];
        fix_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!tx_en) begin
          gap_d   = GW'(GAP_CYCLES);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap - GW'(1);
        if (gap <= GW'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase

    if (fix) begin
      if (!vld) begin
        data_d = fix_byte;
        vld_d  = 1'b1;
      end else if (tx_rd) begin
        vld_d   = 1'b0;
        state_d = fix_next;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: table-driven and scoreboard bench for usb_tx_sched.
// A small usb_tx model takes bytes and raises/drops tx_en around packets.
module tb_usb_tx_sched;

  localparam int GAP  = 16;
  localparam int MAXL = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_req;
  logic [1:0] hs_pid;
  logic       hs_ack;
  logic       dat_req;
  logic       dat_pid;
  logic [6:0] dat_len;
  logic       dat_ack;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_rd;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_rd = 1'b0;
  logic       tx_en = 1'b0;
  logic       busy;
  logic       underrun;

  usb_tx_sched #(
    .GAP_CYCLES (GAP),
    .MAX_LEN    (MAXL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hs_req   (hs_req),
    .hs_pid   (hs_pid),
    .hs_ack   (hs_ack),
    .dat_req  (dat_req),
    .dat_pid  (dat_pid),
    .dat_len  (dat_len),
    .dat_ack  (dat_ack),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_rd    (pl_rd),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_rd    (tx_rd),
    .tx_en    (tx_en),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         hs;
    bit [1:0]   hsel;
    bit         dpid;
    int         len;
    int         avail;
    logic [7:0] epid;
    int         erd;
    bit         eund;
  } vec_t;

  vec_t vt [9];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int base = 0;
  int pend = 0;
  int pidx;
  int n_hs = 0;
  int n_dat = 0;
  int n_und = 0;
  int last_take = -1000;
  int en_fall = 0;
  int idle = 0;
  int w = 0;
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] pay [128];
  logic [7:0] exp_q [$];

  assign pidx     = rd_cnt - base;
  assign pl_valid = (pidx >= 0) && (pidx < pend);
  assign pl_data  = pay[pidx[6:0]];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (pl_rd) rd_cnt <= rd_cnt + 1;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference CRC: MSB-first register on the
  // normal polynomial, fed LSB-first, reflected.
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] r;
    logic [15:0] o;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = r[15] ^ pay[i][b];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    for (int k = 0; k < 16; k++) o[k] = r[15-k];
    return ~o;
  endfunction

  // usb_tx model plus pulse counters and byte scoreboard.
  always @(negedge clk) begin
    if (hs_ack) n_hs++;
    if (dat_ack) n_dat++;
    if (underrun) n_und++;
    if (rst) last_take = -1000;
    if (tx_valid && !pv && (cyc - last_take) < 10)
      chk("ifg_cycles", cyc - last_take, 2);
    if (tx_valid && pv)
      chk("tx_data_hold", tx_data, pd);
    pv = tx_valid;
    pd = tx_data;
    if (tx_rd) begin
      tx_rd = 1'b0;
    end else if (tx_valid) begin
      if (w > 0) begin
        w--;
      end else begin
        tx_rd     = 1'b1;
        tx_en     = 1'b1;
        last_take = cyc;
        w         = $urandom_range(0, 2);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_byte: got %02h, expected none",
                   tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_q.pop_front());
        end
      end
    end
    if (tx_valid) begin
      idle = 0;
    end else if (tx_en) begin
      idle++;
      if (idle >= 4) begin
        tx_en   = 1'b0;
        idle    = 0;
        en_fall = cyc;
      end
    end
  end

  task automatic wait_idle(output int at);
    bit done;
    done = 1'b0;
    at   = cyc;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        at   = cyc;
      end
    end
    chk("idle_reached", done, 1);
  endtask

  task automatic run_pkt(input vec_t v,
                         input bit fix,
                         input logic [15:0] cfix);
    logic [15:0] c;
    int h0, d0, u0, r0, at;
    bit got;
    base = rd_cnt;
    pend = v.avail;
    exp_q.push_back(8'h80);
    exp_q.push_back(v.epid);
    for (int i = 0; i < v.erd; i++)
      exp_q.push_back(pay[i]);
    if (!v.hs && !v.eund) begin
      c = fix ? cfix : crc_ref(v.erd);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
    h0 = n_hs;
    d0 = n_dat;
    u0 = n_und;
    r0 = rd_cnt;
    if (v.hs) begin
      hs_pid = v.hsel;
      hs_req = 1'b1;
    end else begin
      dat_pid = v.dpid;
      dat_len = 7'(v.len);
      dat_req = 1'b1;
    end
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = v.hs ? hs_ack : dat_ack;
    end
    chk("grant", got, 1);
    chk("busy_at_grant", busy, 1);
    @(posedge clk);
    #1;
    hs_req  = 1'b0;
    dat_req = 1'b0;
    wait_idle(at);
    chk("queue_left", exp_q.size(), 0);
    chk("pl_rd_count", rd_cnt - r0, v.erd);
    chk("underrun_count", n_und - u0, int'(v.eund));
    chk("hs_ack_count", n_hs - h0, int'(v.hs));
    chk("dat_ack_count", n_dat - d0, int'(!v.hs));
    chk("gap_window",
        int'((at - en_fall) >= GAP &&
             (at - en_fall) <= GAP + 2), 1);
    exp_q.delete();
    pend = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       kv;
    logic [15:0] c;
    bit         got;
    int         at, tg;

    rst     = 1'b1;
    hs_req  = 1'b0;
    hs_pid  = 2'd0;
    dat_req = 1'b0;
    dat_pid = 1'b0;
    dat_len = 7'd0;
    for (int i = 0; i < 128; i++) pay[i] = 8'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        {hs_ack, dat_ack, pl_rd, tx_valid,
         tx_data, busy, underrun}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    vt[0] = '{1, 0, 0, 0,  0,   8'hD2, 0,  0};
    vt[1] = '{1, 1, 0, 0,  0,   8'h5A, 0,  0};
    vt[2] = '{1, 2, 0, 0,  0,   8'h1E, 0,  0};
    vt[3] = '{1, 3, 0, 0,  0,   8'h5A, 0,  0};
    vt[4] = '{0, 0, 0, 0,  128, 8'hC3, 0,  0};
    vt[5] = '{0, 0, 1, 4,  128, 8'h4B, 4,  0};
    vt[6] = '{0, 0, 0, 70, 128, 8'hC3, 64, 0};
    vt[7] = '{0, 0, 1, 3,  1,   8'h4B, 1,  1};
    vt[8] = '{0, 0, 1, 1,  128, 8'h4B, 1,  0};

    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 128; i++) pay[i] = 8'(i);
      run_pkt(vt[k], 1'b0, 16'h0000);
    end

    // "123456789" has the published CRC-16/USB value B4C8.
    for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
    kv = '{0, 0, 0, 9, 128, 8'hC3, 9, 0};
    run_pkt(kv, 1'b1, 16'hB4C8);

    // Simultaneous requests: handshake first, data after gap.
    for (int i = 0; i < 128; i++) pay[i] = 8'(8'hA0 + i);
    base = rd_cnt;
    pend = 128;
    c = crc_ref(2);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hD2);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    hs_pid  = 2'd0;
    dat_pid = 1'b1;
    dat_len = 7'd2;
    hs_req  = 1'b1;
    dat_req = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = hs_ack;
    end
    chk("sim_hs_first", got, 1);
    chk("sim_no_dat_ack", dat_ack, 0);
    @(posedge clk);
    #1 hs_req = 1'b0;
    got = 1'b0;
    tg  = cyc;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      got = dat_ack;
      tg  = cyc;
    end
    chk("sim_dat_grant", got, 1);
    chk("sim_gap", int'((tg - en_fall) >= GAP), 1);
    @(posedge clk);
    #1 dat_req = 1'b0;
    wait_idle(at);
    chk("sim_queue_left", exp_q.size(), 0);
    exp_q.delete();
    pend = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of a data packet.
    for (int i = 0; i < 128; i++) pay[i] = 8'(8'h50 + i);
    base = rd_cnt;
    pend = 128;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hC3);
    for (int i = 0; i < 8; i++) exp_q.push_back(pay[i]);
    dat_pid = 1'b0;
    dat_len = 7'd8;
    dat_req = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = dat_ack;
    end
    chk("rst_dat_grant", got, 1);
    @(posedge clk);
    #1 dat_req = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = (rd_cnt - base) >= 2;
    end
    chk("rst_in_data", got, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    pend = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outputs",
        {hs_ack, dat_ack, pl_rd, tx_valid,
         tx_data, busy, underrun}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    hs_pid = 2'd0;
    hs_req = 1'b1;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hD2);
    @(negedge clk);
    chk("rst_then_grant", hs_ack, 1);
    @(posedge clk);
    #1 hs_req = 1'b0;
    wait_idle(at);
    chk("rst_queue_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
